// File: rtl/fpu_seq_pkg.sv
// Shared types and helpers for the FP multicycle sequencer: state encoding,
// FP opcode encoding and the per-op latency selector.
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WB   = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FP_ADD = 2'b00,
    FP_SUB = 2'b01,
    FP_MUL = 2'b10,
    FP_CMP = 2'b11
  } fp_op_e;

  // FADD and FSUB share the adder pipeline, hence the same latency.
  function automatic int lat_of(input fp_op_e op, input int add_lat,
                                input int mul_lat, input int cmp_lat);
    case (op)
      FP_MUL:  return mul_lat;
      FP_CMP:  return cmp_lat;
      default: return add_lat;
    endcase
  endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable down-counter that saturates at zero; the zero flag tells the
// sequencer the final execute cycle has been reached.
module fpu_lat_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/fpu_sequencer.sv
// Multicycle FP operation sequencer: accepts one op from decode, stalls the
// controller for the op latency, then issues the gated commit strobe.
module fpu_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 4,
  parameter int CMP_LAT = 1,
  parameter int CNT_W   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic [1:0] FpOp,
  input  logic       CondEx,
  input  logic       Cancel,
  output logic       FpuEn,
  output logic [1:0] FpuOp,
  output logic       Busy,
  output logic       Done,
  output logic       FPUWrite,
  output logic       FlagWrite
);

  // Reject latencies the counter cannot represent.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("fpu_sequencer: CNT_W must be at least 1");
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lat_chk
    localparam int LAT = lat_of(fp_op_e'(2'(gi)), ADD_LAT, MUL_LAT, CMP_LAT);
    if ((LAT < 1) || (LAT > (2 ** CNT_W))) begin : g_bad_lat
      $error("fpu_sequencer: latency out of range for op %0d", gi);
    end
  end

  state_e           state_reg, state_next;
  fp_op_e           fpu_op_reg, fpu_op_next;
  logic             cond_reg, cond_next;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] lat_m1;

  assign lat_m1 = CNT_W'(lat_of(fp_op_e'(FpOp), ADD_LAT, MUL_LAT, CMP_LAT) - 1);

  fpu_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .clk     (clk),
    .srst    (reset),
    .load    (cnt_load),
    .load_val(lat_m1),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      fpu_op_reg <= FP_ADD;
      cond_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      fpu_op_reg <= fpu_op_next;
      cond_reg   <= cond_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    fpu_op_next = fpu_op_reg;
    cond_next   = cond_reg;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Start && !Cancel) begin
          fpu_op_next = fp_op_e'(FpOp);
          cond_next   = CondEx;
          // A failed condition skips the datapath and only reports completion.
          if (CondEx) begin
            state_next = RUN;
            cnt_load   = 1'b1;
          end else begin
            state_next = WB;
          end
        end
      end
      RUN: begin
        if (Cancel) begin
          state_next = IDLE;
        end else if (cnt_zero) begin
          state_next = WB;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WB: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign FpuEn     = (state_reg == RUN);
  assign Busy      = (state_reg == RUN);
  assign Done      = (state_reg == WB);
  assign FpuOp     = fpu_op_reg;
  assign FPUWrite  = (state_reg == WB) && cond_reg && (fpu_op_reg != FP_CMP);
  assign FlagWrite = (state_reg == WB) && cond_reg && (fpu_op_reg == FP_CMP);

endmodule

// File: tb/tb_fpu_sequencer.sv
// Randomised scoreboard bench for fpu_sequencer: a timeline model predicts
// each completion, a monitor checks every cycle after the clock edge.
module tb_fpu_sequencer;

  localparam int ADD_LAT = 3;
  localparam int MUL_LAT = 4;
  localparam int CMP_LAT = 1;
  localparam int CNT_W   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       Start;
  logic [1:0] FpOp;
  logic       CondEx;
  logic       Cancel;
  logic       FpuEn;
  logic [1:0] FpuOp;
  logic       Busy;
  logic       Done;
  logic       FPUWrite;
  logic       FlagWrite;

  fpu_sequencer #(
    .ADD_LAT(ADD_LAT),
    .MUL_LAT(MUL_LAT),
    .CMP_LAT(CMP_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .FpOp     (FpOp),
    .CondEx   (CondEx),
    .Cancel   (Cancel),
    .FpuEn    (FpuEn),
    .FpuOp    (FpuOp),
    .Busy     (Busy),
    .Done     (Done),
    .FPUWrite (FPUWrite),
    .FlagWrite(FlagWrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [1:0] op;
    logic       fw;
    logic       flw;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  // Model: the current op occupies edges m_t..m_wb; idle again from m_wb+2 on.
  int         m_t     = 0;
  int         m_wb    = -10;
  logic       m_cond  = 1'b0;
  logic       m_valid = 1'b0;
  logic [1:0] m_op    = 2'b00;

  function automatic int lat(input logic [1:0] op);
    case (op)
      2'b10:   return MUL_LAT;
      2'b11:   return CMP_LAT;
      default: return ADD_LAT;
    endcase
  endfunction

  task automatic apply(input logic rst, input logic s, input logic [1:0] op,
                       input logic c, input logic can);
    int k;
    exp_t e;
    reset  = rst;
    Start  = s;
    FpOp   = op;
    CondEx = c;
    Cancel = can;
    k = edge_cnt + 1;
    if (rst) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_op    = 2'b00;
      m_wb    = k - 1;
    end else if (k >= m_wb + 2) begin
      if (s && !can) begin
        m_valid = 1'b1;
        m_t     = k;
        m_cond  = c;
        m_op    = op;
        m_wb    = k + (c ? lat(op) : 0);
        e.edge_no = m_wb;
        e.op      = op;
        e.fw      = c && (op != 2'b11);
        e.flw     = c && (op == 2'b11);
        exp_q.push_back(e);
      end
    end else if (can && (k <= m_wb)) begin
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      m_wb = k - 1;
    end
  endtask

  task automatic drive(input logic rst, input logic s, input logic [1:0] op,
                       input logic c, input logic can);
    @(negedge clk);
    apply(rst, s, op, c, can);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_cnt, act, req);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always begin
    logic exp_busy;
    exp_t e;
    @(posedge clk);
    edge_cnt++;
    #1;
    exp_busy = m_valid && m_cond && (edge_cnt >= m_t) && (edge_cnt < m_wb);
    check("busy", int'(Busy), int'(exp_busy));
    check("fpuen", int'(FpuEn), int'(exp_busy));
    check("fpuop", int'(FpuOp), int'(m_op));
    if (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
      e = exp_q.pop_front();
      check("done_missed", 0, 1);
    end
    if (Done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_time", edge_cnt, e.edge_no);
        check("done_op", int'(FpuOp), int'(e.op));
        check("fpuwrite", int'(FPUWrite), int'(e.fw));
        check("flagwrite", int'(FlagWrite), int'(e.flw));
      end
    end else begin
      check("strobe_idle", int'(FPUWrite | FlagWrite), 0);
    end
  end

  initial begin
    apply(1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    // FMUL full run, FCMP, condition-failed FADD
    drive(1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
    repeat (6) drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    // FMUL cancelled mid-run, then Start with Cancel in IDLE
    drive(1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    // FADD with an ignored second Start, then back-to-back restarts
    drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
    repeat (8) drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
    // Reset mid-operation
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 1) == 1),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 11) == 0));
    end
    repeat (12) drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
